// File: rtl/mult_stream_server_pkg.sv
// mult_stream_server_pkg
// Shared types and helpers for the digit-serial multiply server.
//   state_t     : FSM encoding (IDLE, CALC, DONE)
//   num_digits  : number of DIGIT_BITS slices needed to cover FIELD_BITS
//   field_a/b   : extract operand a (low field) / b (next field) from a request beat
// The extract helpers work on a MAX_DAT_BITS-wide view of the beat; callers cast
// the result down to FIELD_BITS. DAT_BITS must not exceed MAX_DAT_BITS.
package mult_stream_server_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_DAT_BITS = 1024;

    function automatic int num_digits(input int field_bits, input int digit_bits);
        return (field_bits + digit_bits - 1) / digit_bits;
    endfunction

    function automatic logic [MAX_DAT_BITS-1:0] field_mask(input int field_bits);
        logic [MAX_DAT_BITS-1:0] mask;
        mask = '1;
        return mask >> (MAX_DAT_BITS - field_bits);
    endfunction

    function automatic logic [MAX_DAT_BITS-1:0] field_a(input logic [MAX_DAT_BITS-1:0] dat,
                                                        input int field_bits);
        return dat & field_mask(field_bits);
    endfunction

    function automatic logic [MAX_DAT_BITS-1:0] field_b(input logic [MAX_DAT_BITS-1:0] dat,
                                                        input int field_bits);
        return (dat >> field_bits) & field_mask(field_bits);
    endfunction

endpackage

// File: rtl/if_axi_stream.sv
// if_axi_stream
// Single-lane streaming interface.
//   val/rdy : a beat transfers on a clock edge where both are 1. The source holds
//             val, dat, ctl, sop, eop, err and mod stable until that edge; the sink
//             may raise or drop rdy at any time.
//   dat     : payload, DAT_BITS wide
//   ctl     : sideband, CTL_BITS wide
//   sop/eop : first/last beat of a packet
//   err     : beat carries an error
//   mod     : count of unused payload bytes on the last beat
interface if_axi_stream #(
    parameter int DAT_BITS = 64,
    parameter int CTL_BITS = 8,
    parameter int MOD_BITS = (DAT_BITS > 15) ? $clog2(DAT_BITS / 8) : 1
);
    logic                val;
    logic                rdy;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic                sop;
    logic                eop;
    logic                err;
    logic [MOD_BITS-1:0] mod;

    modport source (output val, dat, ctl, sop, eop, err, mod, input rdy);
    modport sink   (input  val, dat, ctl, sop, eop, err, mod, output rdy);
endinterface

// File: rtl/mult_digit_mac.sv
// mult_digit_mac
// Combinational multiply-accumulate step: sum = acc + ((a * digit) << shift).
//   acc   : running partial product, ACC_BITS
//   a     : full-width operand, FIELD_BITS
//   digit : one DIGIT_BITS slice of the other operand
//   shift : bit position of that slice
//   sum   : updated partial product
// Kept as its own block so the multiplier can be retimed or mapped onto DSPs.
module mult_digit_mac #(
    parameter int FIELD_BITS = 257,
    parameter int DIGIT_BITS = 32,
    parameter int ACC_BITS   = 2 * FIELD_BITS,
    parameter int SHIFT_BITS = 9
) (
    input  logic [ACC_BITS-1:0]   acc,
    input  logic [FIELD_BITS-1:0] a,
    input  logic [DIGIT_BITS-1:0] digit,
    input  logic [SHIFT_BITS-1:0] shift,
    output logic [ACC_BITS-1:0]   sum
);
    localparam int PROD_BITS = FIELD_BITS + DIGIT_BITS;

    logic [PROD_BITS-1:0] prod;

    assign prod = {{DIGIT_BITS{1'b0}}, a} * {{FIELD_BITS{1'b0}}, digit};

    // The shifted slice product never carries past ACC_BITS because the
    // padding above FIELD_BITS in the top digit is zero.
    assign sum = acc + (ACC_BITS'(prod) << shift);
endmodule

// File: rtl/mult_stream_server.sv
// mult_stream_server
// Responder for the multiply channel: takes one beat {b, a} and returns a*b,
// computing it one DIGIT_BITS slice of b per clock.
//   i_clk     : clock
//   i_rst_n   : asynchronous active-low reset
//   i_req_if  : request sink, a = dat[0 +: FIELD_BITS], b = dat[FIELD_BITS +: FIELD_BITS];
//               bits above 2*FIELD_BITS and sop/eop/mod/err are ignored
//   o_res_if  : result source, single beat, product zero-extended into dat, ctl echoed
//   dbg_state : current FSM state
// Optional build macro MULT_STREAM_SERVER_OVERLAP_EN: the result register doubles as a
// holding slot so a second request can be computed while the first result waits for
// o_res_if.rdy (at most two operations in flight, results in request order).
module mult_stream_server
    import mult_stream_server_pkg::*;
#(
    parameter int FIELD_BITS = 257,
    parameter int DIGIT_BITS = 32,
    parameter int CTL_BITS   = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    if_axi_stream.sink    i_req_if,
    if_axi_stream.source  o_res_if,
    output state_t        dbg_state
);
    localparam int N          = num_digits(FIELD_BITS, DIGIT_BITS);
    localparam int ACC_BITS   = 2 * FIELD_BITS;
    localparam int DAT_BITS   = 2 * (FIELD_BITS + 1);
    localparam int B_BITS     = N * DIGIT_BITS;
    localparam int CNT_BITS   = (N > 1) ? $clog2(N) : 1;
    localparam int SHIFT_BITS = (B_BITS > 1) ? $clog2(B_BITS) : 1;
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(N - 1);

    state_t                state;
    logic [FIELD_BITS-1:0] a_in;
    logic [FIELD_BITS-1:0] b_in;
    logic [FIELD_BITS-1:0] a_q;
    logic [B_BITS-1:0]     b_q;      // b zero-padded to whole digits, consumed low digit first
    logic [CTL_BITS-1:0]   ctl_q;
    logic [ACC_BITS-1:0]   acc;
    logic [ACC_BITS-1:0]   mac_sum;
    logic [CNT_BITS-1:0]   cnt;
    logic [SHIFT_BITS-1:0] shift;
    logic                  req_hs;
    logic                  res_hs;
`ifdef MULT_STREAM_SERVER_OVERLAP_EN
    logic                  loaded;   // result of the current op already sits in the output register
`endif

    assign a_in      = FIELD_BITS'(field_a(MAX_DAT_BITS'(i_req_if.dat), FIELD_BITS));
    assign b_in      = FIELD_BITS'(field_b(MAX_DAT_BITS'(i_req_if.dat), FIELD_BITS));
    assign req_hs    = i_req_if.val && i_req_if.rdy;
    assign res_hs    = o_res_if.val && o_res_if.rdy;
    assign dbg_state = state;

    always_comb begin
        shift = SHIFT_BITS'(int'(cnt) * DIGIT_BITS);
    end

    mult_digit_mac #(
        .FIELD_BITS (FIELD_BITS),
        .DIGIT_BITS (DIGIT_BITS),
        .ACC_BITS   (ACC_BITS),
        .SHIFT_BITS (SHIFT_BITS)
    ) u_mac (
        .acc   (acc),
        .a     (a_q),
        .digit (b_q[DIGIT_BITS-1:0]),
        .shift (shift),
        .sum   (mac_sum)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            i_req_if.rdy  <= 1'b0;
            o_res_if.val  <= 1'b0;
            o_res_if.dat  <= '0;
            o_res_if.ctl  <= '0;
            o_res_if.sop  <= 1'b0;
            o_res_if.eop  <= 1'b0;
            o_res_if.err  <= 1'b0;
            o_res_if.mod  <= '0;
            a_q           <= '0;
            b_q           <= '0;
            ctl_q         <= '0;
            acc           <= '0;
            cnt           <= '0;
`ifdef MULT_STREAM_SERVER_OVERLAP_EN
            loaded        <= 1'b0;
`endif
        end else begin
            // A load later in this block overrides the clear.
            if (res_hs) begin
                o_res_if.val <= 1'b0;
            end

            case (state)
                IDLE: begin
                    i_req_if.rdy <= 1'b1;
                    if (req_hs) begin
                        a_q          <= a_in;
                        b_q          <= B_BITS'(b_in);
                        ctl_q        <= i_req_if.ctl;
                        acc          <= '0;
                        cnt          <= '0;
                        i_req_if.rdy <= 1'b0;
                        state        <= CALC;
                    end
                end

                CALC: begin
                    acc <= mac_sum;
                    b_q <= b_q >> DIGIT_BITS;
                    cnt <= cnt + CNT_BITS'(1);
                    if (cnt == LAST_CNT) begin
                        state <= DONE;
`ifdef MULT_STREAM_SERVER_OVERLAP_EN
                        // Load straight away when the output slot is empty or is
                        // being emptied on this very edge.
                        if (!o_res_if.val || o_res_if.rdy) begin
                            o_res_if.val <= 1'b1;
                            o_res_if.dat <= DAT_BITS'(mac_sum);
                            o_res_if.ctl <= ctl_q;
                            o_res_if.sop <= 1'b1;
                            o_res_if.eop <= 1'b1;
                            o_res_if.err <= 1'b0;
                            o_res_if.mod <= '0;
                            loaded       <= 1'b1;
                        end else begin
                            loaded       <= 1'b0;
                        end
`else
                        o_res_if.val <= 1'b1;
                        o_res_if.dat <= DAT_BITS'(mac_sum);
                        o_res_if.ctl <= ctl_q;
                        o_res_if.sop <= 1'b1;
                        o_res_if.eop <= 1'b1;
                        o_res_if.err <= 1'b0;
                        o_res_if.mod <= '0;
`endif
                    end
                end

                DONE: begin
`ifdef MULT_STREAM_SERVER_OVERLAP_EN
                    if (loaded) begin
                        i_req_if.rdy <= 1'b1;
                        state        <= IDLE;
                    end else if (!o_res_if.val) begin
                        // Previous result left on the last edge; acc has been held.
                        o_res_if.val <= 1'b1;
                        o_res_if.dat <= DAT_BITS'(acc);
                        o_res_if.ctl <= ctl_q;
                        o_res_if.sop <= 1'b1;
                        o_res_if.eop <= 1'b1;
                        o_res_if.err <= 1'b0;
                        o_res_if.mod <= '0;
                        loaded       <= 1'b1;
                    end
`else
                    if (res_hs) begin
                        i_req_if.rdy <= 1'b1;
                        state        <= IDLE;
                    end
`endif
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_stream_server.sv
module tb_mult_stream_server;
    import mult_stream_server_pkg::*;

    localparam int FIELD_BITS = 257;
    localparam int DIGIT_BITS = 32;
    localparam int CTL_BITS   = 8;
    localparam int DAT_BITS   = 2 * (FIELD_BITS + 1);
    localparam int PROD_BITS  = 2 * FIELD_BITS;
    localparam int N          = 9;
    localparam int W          = DAT_BITS + CTL_BITS;
    localparam int BUDGET     = 300;
`ifdef MULT_STREAM_SERVER_OVERLAP_EN
    localparam int MAX_INFLIGHT = 2;
`else
    localparam int MAX_INFLIGHT = 1;
`endif

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    always #5 clk = ~clk;

    if_axi_stream #(.DAT_BITS(DAT_BITS), .CTL_BITS(CTL_BITS)) req_if ();
    if_axi_stream #(.DAT_BITS(DAT_BITS), .CTL_BITS(CTL_BITS)) res_if ();

    mult_stream_server #(
        .FIELD_BITS (FIELD_BITS),
        .DIGIT_BITS (DIGIT_BITS),
        .CTL_BITS   (CTL_BITS)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req_if  (req_if),
        .o_res_if  (res_if),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           rdy_mode = 0;      // 0: always ready, 1: hold off, 2: random
    int           accepted = 0;
    int           completed = 0;
    int           max_inflight = 0;
    logic         hold_pending = 1'b0;
    logic [W-1:0] held = '0;

    task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain wide multiplication of the two fields.
    function automatic logic [W-1:0] model(input logic [FIELD_BITS-1:0] a,
                                           input logic [FIELD_BITS-1:0] b,
                                           input logic [CTL_BITS-1:0] c);
        logic [PROD_BITS-1:0] p;
        p = PROD_BITS'(a) * PROD_BITS'(b);
        return {c, DAT_BITS'(p)};
    endfunction

    function automatic logic [FIELD_BITS-1:0] rand_field();
        logic [9*32-1:0] t;
        int sel;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom();
        sel = $urandom_range(0, 9);
        case (sel)
            0:       return '0;
            1:       return '1;
            2:       return FIELD_BITS'($urandom_range(0, 255));
            default: return t[FIELD_BITS-1:0];
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending)
                check("hold_stable", (W+1)'({res_if.val, res_if.ctl, res_if.dat}), {1'b1, held});
            case (rdy_mode)
                0:       res_if.rdy = 1'b1;
                1:       res_if.rdy = 1'b0;
                default: res_if.rdy = ($urandom_range(0, 3) != 0);
            endcase
            if (res_if.val && res_if.rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat got %0h expected none", {res_if.ctl, res_if.dat});
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("result", (W+1)'({res_if.ctl, res_if.dat}), (W+1)'(e));
                    check("framing", (W+1)'({res_if.sop, res_if.eop, res_if.err, res_if.mod}),
                          (W+1)'(9'b110_000000));
                end
                completed++;
                hold_pending = 1'b0;
            end else if (res_if.val) begin
                hold_pending = 1'b1;
                held = {res_if.ctl, res_if.dat};
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send(input logic [FIELD_BITS-1:0] a, input logic [FIELD_BITS-1:0] b,
                        input logic [CTL_BITS-1:0] c, input logic [1:0] junk);
        logic [DAT_BITS-1:0] d;
        int w;
        d = '0;
        d[FIELD_BITS-1:0] = a;
        d[2*FIELD_BITS-1:FIELD_BITS] = b;
        d[DAT_BITS-1:2*FIELD_BITS] = junk;
        req_if.val = 1'b1;
        req_if.dat = d;
        req_if.ctl = c;
        req_if.sop = junk[0];
        req_if.eop = junk[1];
        w = 0;
        while (!req_if.rdy && w < BUDGET) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!req_if.rdy) begin
            errors++;
            $display("FAIL accept_timeout got rdy=0 after %0d cycles expected rdy=1", w);
            req_if.val = 1'b0;
            return;
        end
        // rdy is registered, so it is still 1 at the coming edge: accept happens there.
        exp_q.push_back(model(a, b, c));
        accepted++;
        if (accepted - completed > max_inflight) max_inflight = accepted - completed;
        @(negedge clk);
        req_if.val = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < BUDGET * 10) begin
            @(negedge clk);
            w++;
        end
        check("drain", (W+1)'(exp_q.size()), '0);
        repeat (2) @(negedge clk);
    endtask

    // Accept cycle counts as cycle 1; val is registered at the N-th edge after it.
    task automatic latency_case(input logic [FIELD_BITS-1:0] a, input logic [FIELD_BITS-1:0] b,
                                input logic [CTL_BITS-1:0] c);
        int k;
        rdy_mode = 1;
        send(a, b, c, 2'b00);
        k = 0;
        while (!res_if.val && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("latency", (W+1)'(k), (W+1)'(N));
        rdy_mode = 0;
        drain();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [FIELD_BITS-1:0] ones;
        ones = '1;
        req_if.val = 1'b0;
        req_if.dat = '0;
        req_if.ctl = '0;
        req_if.sop = 1'b0;
        req_if.eop = 1'b0;
        req_if.err = 1'b0;
        req_if.mod = '0;
        res_if.rdy = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_req_rdy", (W+1)'(req_if.rdy), '0);
        check("rst_res_val", (W+1)'(res_if.val), '0);
        check("rst_res_dat_ctl", (W+1)'({res_if.ctl, res_if.dat}), '0);
        check("rst_res_flags", (W+1)'({res_if.sop, res_if.eop, res_if.err, res_if.mod}), '0);
        check("rst_state", (W+1)'(dbg_state), (W+1)'(IDLE));
        #2 rst_n = 1'b1;
        #1 check("rdy_before_edge", (W+1)'(req_if.rdy), '0);
        @(negedge clk);
        check("rdy_after_first_edge", (W+1)'(req_if.rdy), (W+1)'(1));

        // Latency and boundary operands
        latency_case(FIELD_BITS'(3), FIELD_BITS'(5), 8'hA5);
        latency_case('0, ones, 8'h11);
        send(ones, ones, 8'h22, 2'b11);
        send('0, ones, 8'h33, 2'b11);
        send(ones, '0, 8'h44, 2'b10);
        send(FIELD_BITS'(1), ones, 8'h55, 2'b01);
        drain();

        // Output backpressure for 20 cycles
        rdy_mode = 1;
        send(FIELD_BITS'(11), FIELD_BITS'(13), 8'h3C, 2'b00);
        for (int k = 0; k < 100 && !res_if.val; k++) @(negedge clk);
        check("hold_val_seen", (W+1)'(res_if.val), (W+1)'(1));
`ifdef MULT_STREAM_SERVER_OVERLAP_EN
        send(FIELD_BITS'(7), FIELD_BITS'(9), 8'h5A, 2'b00);
        repeat (17) @(negedge clk);
`else
        for (int k = 0; k < 20; k++) begin
            check("req_rdy_low_while_held", (W+1)'(req_if.rdy), '0);
            @(negedge clk);
        end
`endif
        rdy_mode = 0;
        drain();

        // Reset during CALC cycle 4
        send(FIELD_BITS'(123), FIELD_BITS'(456), 8'hC3, 2'b00);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_res_val", (W+1)'(res_if.val), '0);
        check("abort_req_rdy", (W+1)'(req_if.rdy), '0);
        check("abort_state", (W+1)'(dbg_state), (W+1)'(IDLE));
        exp_q.delete();
        completed = accepted;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send(FIELD_BITS'(7), FIELD_BITS'(9), 8'h77, 2'b00);
        drain();
        repeat (20) @(negedge clk);

        // Random traffic with random backpressure
        rdy_mode = 2;
        for (int r = 0; r < 200; r++) begin
            send(rand_field(), rand_field(), CTL_BITS'($urandom()), 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        checks++;
        if (max_inflight > MAX_INFLIGHT) begin
            errors++;
            $display("FAIL max_inflight got %0d expected at most %0d", max_inflight, MAX_INFLIGHT);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
